// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execution-unit result ports and the register-file write port.
// The master drives results; the slave (the arbiter) drives the write port and status.
interface wb_arbiter_if #(
   parameter int AW = 6,
   parameter int DW = 32
);
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_dd_val;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dd_val;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_dd_val;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_val;
   logic          stall;
   logic          ovf;

   modport master (
      output alu_addr, alu_dd_val, mem_addr, mem_dd_val, io_addr, io_dd_val,
      input  wb_addr, wb_val, stall, ovf
   );

   modport slave (
      input  alu_addr, alu_dd_val, mem_addr, mem_dd_val, io_addr, io_dd_val,
      output wb_addr, wb_val, stall, ovf
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: three per-source result FIFOs drained one entry per cycle onto the
// register-file write port, fixed priority mem > io > alu with a per-source starvation guard.
module wb_arbiter #(
   parameter int DEPTH  = 4,
   parameter int AW     = 6,
   parameter int DW     = 32,
   parameter int STARVE = 8
) (
   input logic        clk,
   input logic        rstn,
   wb_arbiter_if.slave bus
);
   localparam int NS = 3;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (STARVE > 1) ? $clog2(STARVE) : 1;
   localparam int EW = AW + DW;

   localparam logic [1:0]    SRC_ALU    = 2'd0;
   localparam logic [1:0]    SRC_MEM    = 2'd1;
   localparam logic [1:0]    SRC_IO     = 2'd2;
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_CNT  = CW'(DEPTH - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE - 1);

   logic [EW-1:0] r_fifo   [NS][DEPTH];
   logic [PW-1:0] r_rd_ptr [NS];
   logic [PW-1:0] r_wr_ptr [NS];
   logic [CW-1:0] r_cnt    [NS];
   logic [SW-1:0] r_starve [NS];
   logic [AW-1:0] r_wb_addr;
   logic [DW-1:0] r_wb_val;
   logic          r_stall;
   logic          r_ovf;

   logic [AW-1:0] w_in_addr  [NS];
   logic [DW-1:0] w_in_val   [NS];
   logic [CW-1:0] w_cnt_next [NS];
   logic [NS-1:0] w_nonempty;
   logic [NS-1:0] w_at_limit;
   logic [NS-1:0] w_grant;
   logic [NS-1:0] w_push;
   logic [NS-1:0] w_accept;
   logic [NS-1:0] w_drop;
   logic [EW-1:0] w_win_entry;
   logic          w_stall_next;

   assign w_in_addr[SRC_ALU] = bus.alu_addr;
   assign w_in_val[SRC_ALU]  = bus.alu_dd_val;
   assign w_in_addr[SRC_MEM] = bus.mem_addr;
   assign w_in_val[SRC_MEM]  = bus.mem_dd_val;
   assign w_in_addr[SRC_IO]  = bus.io_addr;
   assign w_in_val[SRC_IO]   = bus.io_dd_val;

   assign bus.wb_addr = r_wb_addr;
   assign bus.wb_val  = r_wb_val;
   assign bus.stall   = r_stall;
   assign bus.ovf     = r_ovf;

   function automatic logic [NS-1:0] pick_fixed(input logic [NS-1:0] req);
      logic [NS-1:0] g;
      g = {NS{1'b0}};
      if (req[SRC_MEM]) begin
         g[SRC_MEM] = 1'b1;
      end else if (req[SRC_IO]) begin
         g[SRC_IO] = 1'b1;
      end else if (req[SRC_ALU]) begin
         g[SRC_ALU] = 1'b1;
      end else begin
         g = {NS{1'b0}};
      end
      return g;
   endfunction

   // Arbitration on pre-edge FIFO state; starved heads take precedence over the fixed order.
   always_comb begin
      w_grant = {NS{1'b0}};
      for (int i = 0; i < NS; i++) begin
         w_nonempty[i] = (r_cnt[i] != {CW{1'b0}});
         w_at_limit[i] = w_nonempty[i] && (r_starve[i] == STARVE_MAX);
      end
      if (|w_at_limit) begin
         w_grant = pick_fixed(w_at_limit);
      end else begin
         w_grant = pick_fixed(w_nonempty);
      end
   end

   // Push acceptance: a full FIFO still takes a push when its head is popped at the same edge.
   always_comb begin
      w_win_entry  = {EW{1'b0}};
      w_stall_next = 1'b0;
      for (int i = 0; i < NS; i++) begin
         w_push[i]     = (w_in_addr[i] != {AW{1'b0}});
         w_accept[i]   = w_push[i] && ((r_cnt[i] != FULL_CNT) || w_grant[i]);
         w_drop[i]     = w_push[i] && !w_accept[i];
         w_cnt_next[i] = r_cnt[i] + CW'(w_accept[i]) - CW'(w_grant[i]);
         w_win_entry   = w_win_entry | ({EW{w_grant[i]}} & r_fifo[i][r_rd_ptr[i]]);
         w_stall_next  = w_stall_next | (w_cnt_next[i] >= STALL_CNT);
      end
   end

   // Storage carries no reset; pointers and counts alone define which entries are valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (w_accept[i]) begin
            r_fifo[i][r_wr_ptr[i]] <= {w_in_addr[i], w_in_val[i]};
         end
      end
   end

   // Pointers, counts and starvation counters per source.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NS; i++) begin
            r_rd_ptr[i] <= {PW{1'b0}};
            r_wr_ptr[i] <= {PW{1'b0}};
            r_cnt[i]    <= {CW{1'b0}};
            r_starve[i] <= {SW{1'b0}};
         end
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (w_accept[i]) begin
               r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
            end
            if (w_grant[i]) begin
               r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
            end
            r_cnt[i] <= w_cnt_next[i];
            if (!w_nonempty[i] || w_grant[i]) begin
               r_starve[i] <= {SW{1'b0}};
            end else if (r_starve[i] != STARVE_MAX) begin
               r_starve[i] <= r_starve[i] + SW'(1);
            end else begin
               r_starve[i] <= r_starve[i];
            end
         end
      end
   end

   // Registered write port and status; overflow is sticky until reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wb_addr <= {AW{1'b0}};
         r_wb_val  <= {DW{1'b0}};
         r_stall   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_wb_addr <= w_win_entry[EW-1:DW];
         r_wb_val  <= w_win_entry[DW-1:0];
         r_stall   <= w_stall_next;
         r_ovf     <= r_ovf | (|w_drop);
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared every cycle,
// plus literal expectations for each directed scenario.
module tb_wb_arbiter;
   localparam int DEPTH  = 4;
   localparam int AW     = 6;
   localparam int DW     = 32;
   localparam int STARVE = 8;
   localparam int EW     = AW + DW;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   wb_arbiter_if #(.AW(AW), .DW(DW)) bus();

   wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .STARVE(STARVE)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Source index: 0 = alu, 1 = mem, 2 = io
   logic [EW-1:0] q_alu[$];
   logic [EW-1:0] q_mem[$];
   logic [EW-1:0] q_io[$];
   int            starve[3];
   int            prio[3] = '{1, 2, 0};
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_val;
   logic          exp_stall;
   logic          exp_ovf;
   logic [AW-1:0] wb_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int qsize(input int s);
      case (s)
         0:       return q_alu.size();
         1:       return q_mem.size();
         default: return q_io.size();
      endcase
   endfunction

   task automatic qpush(input int s, input logic [EW-1:0] e);
      case (s)
         0:       q_alu.push_back(e);
         1:       q_mem.push_back(e);
         default: q_io.push_back(e);
      endcase
   endtask

   task automatic qpop(input int s, output logic [EW-1:0] e);
      case (s)
         0:       e = q_alu.pop_front();
         1:       e = q_mem.pop_front();
         default: e = q_io.pop_front();
      endcase
   endtask

   task automatic model_reset();
      q_alu.delete();
      q_mem.delete();
      q_io.delete();
      for (int s = 0; s < 3; s++) starve[s] = 0;
      exp_addr  = '0;
      exp_val   = '0;
      exp_stall = 1'b0;
      exp_ovf   = 1'b0;
   endtask

   // One clock edge of the reference model, using the inputs present at that edge.
   task automatic model_step();
      int            win;
      logic [EW-1:0] e;
      logic [AW-1:0] a[3];
      logic [DW-1:0] v[3];
      a[0] = bus.alu_addr; v[0] = bus.alu_dd_val;
      a[1] = bus.mem_addr; v[1] = bus.mem_dd_val;
      a[2] = bus.io_addr;  v[2] = bus.io_dd_val;
      win = -1;
      for (int k = 0; k < 3; k++)
         if (win < 0 && qsize(prio[k]) > 0 && starve[prio[k]] == STARVE - 1) win = prio[k];
      for (int k = 0; k < 3; k++)
         if (win < 0 && qsize(prio[k]) > 0) win = prio[k];
      for (int s = 0; s < 3; s++) begin
         if (qsize(s) == 0 || s == win) starve[s] = 0;
         else if (starve[s] < STARVE - 1) starve[s]++;
      end
      if (win < 0) begin
         exp_addr = '0;
         exp_val  = '0;
      end else begin
         qpop(win, e);
         exp_addr = e[EW-1:DW];
         exp_val  = e[DW-1:0];
      end
      for (int s = 0; s < 3; s++) begin
         if (a[s] != '0) begin
            if (qsize(s) < DEPTH) qpush(s, {a[s], v[s]});
            else exp_ovf = 1'b1;
         end
      end
      exp_stall = 1'b0;
      for (int s = 0; s < 3; s++) if (qsize(s) >= DEPTH - 1) exp_stall = 1'b1;
   endtask

   // Advance one cycle and compare every DUT output against the model on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (rstn) model_step();
      @(negedge clk);
      chk("wb_addr", 64'(bus.wb_addr), 64'(exp_addr));
      chk("wb_val",  64'(bus.wb_val),  64'(exp_val));
      chk("stall",   64'(bus.stall),   64'(exp_stall));
      chk("ovf",     64'(bus.ovf),     64'(exp_ovf));
      wb_log.push_back(bus.wb_addr);
   endtask

   task automatic set_src(input int s, input logic [AW-1:0] a, input logic [DW-1:0] v);
      case (s)
         0:       begin bus.alu_addr = a; bus.alu_dd_val = v; end
         1:       begin bus.mem_addr = a; bus.mem_dd_val = v; end
         default: begin bus.io_addr  = a; bus.io_dd_val  = v; end
      endcase
   endtask

   task automatic clear_all();
      for (int s = 0; s < 3; s++) set_src(s, '0, '0);
   endtask

   task automatic chk_log(input string name, input int idx, input logic [AW-1:0] req);
      if (idx < wb_log.size()) chk(name, 64'(wb_log[idx]), 64'(req));
      else chk(name, 64'hDEAD, 64'(req));
   endtask

   initial begin
      rstn = 1'b1;
      clear_all();
      model_reset();
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_wb_addr", 64'(bus.wb_addr), 64'h0);
      chk("reset_wb_val",  64'(bus.wb_val),  64'h0);
      chk("reset_stall",   64'(bus.stall),   64'h0);
      chk("reset_ovf",     64'(bus.ovf),     64'h0);
      rstn = 1'b1;
      tick();

      // Single source, two-edge latency, held one cycle
      set_src(0, 6'd5, 32'h1234);
      tick();
      chk("single_no_bypass", 64'(bus.wb_addr), 64'h0);
      clear_all();
      tick();
      chk("single_addr", 64'(bus.wb_addr), 64'd5);
      chk("single_val",  64'(bus.wb_val),  64'h1234);
      tick();
      chk("single_after", 64'(bus.wb_addr), 64'h0);

      // Three results in one cycle drain mem, io, alu
      set_src(1, 6'd3, 32'hA);
      set_src(2, 6'd4, 32'hB);
      set_src(0, 6'd5, 32'hC);
      tick();
      clear_all();
      wb_log.delete();
      repeat (4) begin
         tick();
         chk("simul_stall", 64'(bus.stall), 64'h0);
      end
      chk_log("simul_0", 0, 6'd3);
      chk_log("simul_1", 1, 6'd4);
      chk_log("simul_2", 2, 6'd5);
      chk_log("simul_3", 3, 6'd0);

      // Starvation: alu waits behind a continuous mem stream
      set_src(0, 6'd7, 32'h77);
      set_src(1, 6'd10, 32'h100);
      tick();
      set_src(0, 6'd0, 32'h0);
      wb_log.delete();
      for (int j = 1; j <= 9; j++) begin
         set_src(1, 6'(10 + j), 32'(256 + j));
         tick();
      end
      for (int j = 0; j < 7; j++) chk_log("starve_mem", j, 6'(10 + j));
      chk_log("starve_alu_wins", 7, 6'd7);
      chk_log("starve_mem_resume", 8, 6'd17);
      clear_all();
      repeat (4) tick();

      // Overflow: five alu pushes while mem keeps winning
      set_src(1, 6'd40, 32'h400);
      tick();
      for (int j = 0; j < 5; j++) begin
         set_src(0, 6'(20 + j), 32'(512 + j));
         set_src(1, 6'(41 + j), 32'(1025 + j));
         tick();
         if (j == 1) chk("ovf_stall_cnt2", 64'(bus.stall), 64'h0);
         if (j == 2) chk("ovf_stall_cnt3", 64'(bus.stall), 64'h1);
         if (j == 3) chk("ovf_not_yet",    64'(bus.ovf),   64'h0);
      end
      chk("ovf_set", 64'(bus.ovf), 64'h1);
      clear_all();
      wb_log.delete();
      repeat (6) tick();
      chk_log("ovf_drain_mem", 0, 6'd45);
      for (int j = 0; j < 4; j++) chk_log("ovf_drain_alu", j + 1, 6'(20 + j));
      chk_log("ovf_drain_end", 5, 6'd0);
      chk("ovf_sticky", 64'(bus.ovf), 64'h1);

      // Asynchronous reset with entries still queued
      set_src(2, 6'd8, 32'h88);
      set_src(0, 6'd9, 32'h99);
      tick();
      clear_all();
      tick();
      chk("rst_pre_addr", 64'(bus.wb_addr), 64'd8);
      rstn = 1'b0;
      #1;
      chk("rst_async_addr", 64'(bus.wb_addr), 64'h0);
      chk("rst_async_val",  64'(bus.wb_val),  64'h0);
      chk("rst_async_ovf",  64'(bus.ovf),     64'h0);
      chk("rst_async_stall", 64'(bus.stall),  64'h0);
      model_reset();
      repeat (2) tick();
      rstn = 1'b1;
      wb_log.delete();
      repeat (3) tick();
      for (int j = 0; j < 3; j++) chk_log("rst_no_stale", j, 6'd0);
      set_src(0, 6'd12, 32'hC0DE);
      tick();
      clear_all();
      tick();
      chk("rst_new_addr", 64'(bus.wb_addr), 64'd12);
      chk("rst_new_val",  64'(bus.wb_val),  64'hC0DE);
      tick();
      chk("rst_new_after", 64'(bus.wb_addr), 64'h0);

      // Full alu FIFO pushed and popped on the same edge
      set_src(1, 6'd50, 32'h500);
      tick();
      for (int j = 0; j < 4; j++) begin
         set_src(0, 6'(30 + j), 32'(768 + j));
         if (j < 3) set_src(1, 6'(51 + j), 32'(1281 + j));
         else set_src(1, 6'd0, 32'h0);
         tick();
      end
      chk("full_stall", 64'(bus.stall), 64'h1);
      set_src(0, 6'd34, 32'(772));
      tick();
      chk("full_pop_addr", 64'(bus.wb_addr), 64'd30);
      chk("full_no_ovf",   64'(bus.ovf),     64'h0);
      chk("full_cnt_kept", 64'(bus.stall),   64'h1);
      clear_all();
      wb_log.delete();
      repeat (5) tick();
      for (int j = 0; j < 4; j++) chk_log("full_order", j, 6'(31 + j));
      chk_log("full_end", 4, 6'd0);
      chk("full_ovf_final", 64'(bus.ovf), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
